// File: rtl/am_slot_tagger.sv
// am_slot_tagger
//   Tags each lane's coded block with a one-bit marker flag and reserves one
//   output word per alignment-marker period as a marker slot. Every lane field
//   of a slot is {1'b1, zeros}; every data lane field is {1'b0, block}.
//   Lane 0 occupies the MSBs on both sides.
//
// Ports
//   i_clock   : clock, rising edge
//   i_reset   : synchronous active-high reset
//   i_enable  : global clock enable; low freezes state, counter and o_data
//   i_valid   : qualifies i_data
//   i_data    : N_LANES coded blocks of LEN_CODED_BLOCK bits
//   o_ready   : combinational accept indication to upstream
//   o_valid   : qualifies o_data (feeds the am_insertion stage)
//   o_data    : N_LANES tagged fields of LEN_TAGGED_BLOCK bits
//   o_am_slot : high for one cycle when o_data is a marker slot
module am_slot_tagger #(
  parameter int LEN_CODED_BLOCK  = 66,
  parameter int LEN_TAGGED_BLOCK = 67,
  parameter int N_LANES          = 20,
  parameter int AM_PERIOD        = 16384,
  parameter int NB_COUNTER       = $clog2(AM_PERIOD)
) (
  input  logic                                  i_clock,
  input  logic                                  i_reset,
  input  logic                                  i_enable,
  input  logic                                  i_valid,
  input  logic [LEN_CODED_BLOCK*N_LANES-1:0]    i_data,
  output logic                                  o_ready,
  output logic                                  o_valid,
  output logic [LEN_TAGGED_BLOCK*N_LANES-1:0]   o_data,
  output logic                                  o_am_slot
);

  localparam int unsigned LC = LEN_CODED_BLOCK;
  localparam int unsigned LT = LEN_TAGGED_BLOCK;
  localparam int unsigned NL = N_LANES;
  localparam logic [NB_COUNTER-1:0] TERMINAL = NB_COUNTER'(AM_PERIOD - 2);

  typedef enum logic {
    ST_AM,
    ST_DATA
  } state_t;

  state_t                     r_state;
  state_t                     w_next_state;
  logic [NB_COUNTER-1:0]      r_count;
  logic                       r_valid;
  logic                       r_am_slot;
  logic [LT*NL-1:0]           r_data;
  logic [LT*NL-1:0]           w_tagged;
  logic [LT*NL-1:0]           w_marker;
  logic                       w_accept;

  assign o_ready   = i_enable && (r_state == ST_DATA) && !i_reset;
  assign w_accept  = i_valid && o_ready;
  assign o_valid   = r_valid;
  assign o_am_slot = r_am_slot;
  assign o_data    = r_data;

  // Build both candidate output words lane by lane, preserving lane order.
  always_comb begin
    w_tagged = '0;
    w_marker = '0;
    for (int unsigned i = 0; i < NL; i++) begin
      w_tagged[LT*NL-1-i*LT -: LT] = {1'b0, i_data[LC*NL-1-i*LC -: LC]};
      w_marker[LT*NL-1-i*LT -: LT] = {1'b1, {LC{1'b0}}};
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_AM: begin
        if (i_enable) w_next_state = ST_DATA;
      end
      ST_DATA: begin
        // Last data word of the period: the next emitted word is the slot.
        if (w_accept && (r_count == TERMINAL)) w_next_state = ST_AM;
      end
      default: w_next_state = ST_AM;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= ST_AM;
      r_count   <= '0;
      r_valid   <= 1'b0;
      r_am_slot <= 1'b0;
      r_data    <= '0;
    end else begin
      r_state   <= w_next_state;
      r_valid   <= 1'b0;
      r_am_slot <= 1'b0;
      if (i_enable) begin
        if (r_state == ST_AM) begin
          r_data    <= w_marker;
          r_valid   <= 1'b1;
          r_am_slot <= 1'b1;
          r_count   <= '0;
        end else if (w_accept) begin
          r_data    <= w_tagged;
          r_valid   <= 1'b1;
          r_count   <= r_count + NB_COUNTER'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_am_slot_tagger.sv
module tb_am_slot_tagger;

  localparam int LC = 66;
  localparam int LT = 67;
  localparam int NL = 20;
  localparam int IW = LC * NL;
  localparam int OW = LT * NL;

  // Expected-output codes; values >= 0 name the data word index.
  localparam int R = -3;  // in reset: all outputs zero
  localparam int I = -2;  // no output word, o_data holds
  localparam int S = -1;  // marker slot

  typedef struct {
    bit rst;
    bit en;
    bit val;
    bit rdy;
    int out;
  } vec_t;

  logic          clk;
  logic          rst, en, val;
  logic [IW-1:0] data_a, data_b;
  logic          a_ready, a_valid, a_am;
  logic [OW-1:0] a_data;
  logic          b_ready, b_valid, b_am;
  logic [OW-1:0] b_data;
  int            ka, kb;
  int            n_checks, n_fail;
  vec_t          va[$];
  vec_t          vb[$];

  function automatic logic [IW-1:0] word(input int k);
    logic [IW-1:0] w;
    w = '0;
    for (int i = 0; i < NL; i++) w[IW-1-i*LC -: LC] = LC'(k * 256 + i);
    return w;
  endfunction

  function automatic logic [LT-1:0] exp_field(input int id, input int lane);
    if (id == R) return '0;
    if (id == S) return {1'b1, {LC{1'b0}}};
    return {1'b0, LC'(id * 256 + lane)};
  endfunction

  function automatic vec_t V(input bit r, input bit e, input bit v, input bit rd, input int o);
    vec_t x;
    x.rst = r; x.en = e; x.val = v; x.rdy = rd; x.out = o;
    return x;
  endfunction

  assign data_a = word(ka);
  assign data_b = word(kb);

  am_slot_tagger #(.LEN_CODED_BLOCK(LC), .LEN_TAGGED_BLOCK(LT), .N_LANES(NL), .AM_PERIOD(4)) u_dut_a (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_valid(val), .i_data(data_a),
    .o_ready(a_ready), .o_valid(a_valid), .o_data(a_data), .o_am_slot(a_am)
  );

  am_slot_tagger #(.LEN_CODED_BLOCK(LC), .LEN_TAGGED_BLOCK(LT), .N_LANES(NL), .AM_PERIOD(2)) u_dut_b (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_valid(val), .i_data(data_b),
    .o_ready(b_ready), .o_valid(b_valid), .o_data(b_data), .o_am_slot(b_am)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic run_vec(input int sel, input vec_t v, input int idx, inout int last);
    string         nm;
    logic          acc_a, acc_b, ov, oa;
    logic [OW-1:0] od;
    int            ref_id;
    nm  = (sel != 0) ? "p2" : "p4";
    rst = v.rst; en = v.en; val = v.val;
    #1;
    check_eq($sformatf("%s[%0d].ready", nm, idx), (sel != 0) ? b_ready : a_ready, v.rdy);
    acc_a = val && a_ready;
    acc_b = val && b_ready;
    @(posedge clk);
    #1;
    if (acc_a) ka++;
    if (acc_b) kb++;
    ov = (sel != 0) ? b_valid : a_valid;
    oa = (sel != 0) ? b_am : a_am;
    od = (sel != 0) ? b_data : a_data;
    check_eq($sformatf("%s[%0d].valid", nm, idx), ov, (v.out == S || v.out >= 0));
    check_eq($sformatf("%s[%0d].am_slot", nm, idx), oa, (v.out == S));
    ref_id = (v.out == I) ? last : v.out;
    for (int i = 0; i < NL; i++)
      check_eq($sformatf("%s[%0d].lane%0d", nm, idx, i), od[OW-1-i*LT -: LT], exp_field(ref_id, i));
    if (v.out != I) last = v.out;
  endtask

  initial begin
    int last;
    n_checks = 0; n_fail = 0;
    ka = 0; kb = 0;
    rst = 1'b1; en = 1'b1; val = 1'b1;

    // AM_PERIOD=4: reset, continuous flow, toggling valid, enable gap, mid-period reset
    va.push_back(V(1,1,1,0,R)); va.push_back(V(1,1,1,0,R));
    va.push_back(V(0,1,1,0,S));
    va.push_back(V(0,1,1,1,0)); va.push_back(V(0,1,1,1,1)); va.push_back(V(0,1,1,1,2));
    va.push_back(V(0,1,1,0,S));
    va.push_back(V(0,1,1,1,3)); va.push_back(V(0,1,1,1,4)); va.push_back(V(0,1,1,1,5));
    va.push_back(V(0,1,1,0,S));
    va.push_back(V(0,1,1,1,6)); va.push_back(V(0,1,0,1,I));
    va.push_back(V(0,1,1,1,7)); va.push_back(V(0,1,0,1,I));
    va.push_back(V(0,1,1,1,8)); va.push_back(V(0,1,0,0,S));
    va.push_back(V(0,1,1,1,9)); va.push_back(V(0,1,0,1,I));
    va.push_back(V(0,1,1,1,10));
    for (int i = 0; i < 5; i++) va.push_back(V(0,0,1,0,I));
    va.push_back(V(0,1,1,1,11)); va.push_back(V(0,1,1,0,S));
    va.push_back(V(0,1,1,1,12)); va.push_back(V(0,1,1,1,13));
    va.push_back(V(1,1,1,0,R)); va.push_back(V(1,1,1,0,R));
    va.push_back(V(0,1,1,0,S));
    va.push_back(V(0,1,1,1,14)); va.push_back(V(0,1,1,1,15)); va.push_back(V(0,1,1,1,16));
    va.push_back(V(0,1,1,0,S));

    // AM_PERIOD=2: strict slot/data alternation, then an idle cycle in data state
    vb.push_back(V(1,1,1,0,R)); vb.push_back(V(1,1,1,0,R));
    for (int k = 0; k < 4; k++) begin
      vb.push_back(V(0,1,1,0,S));
      vb.push_back(V(0,1,1,1,k));
    end
    vb.push_back(V(0,1,1,0,S));
    vb.push_back(V(0,1,0,1,I));
    vb.push_back(V(0,1,1,1,4));
    vb.push_back(V(0,1,1,0,S));

    last = R;
    foreach (va[i]) run_vec(0, va[i], i, last);
    ka = 0; kb = 0;
    last = R;
    foreach (vb[i]) run_vec(1, vb[i], i, last);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
